// File: rtl/smin_pkg.sv
// ============================================================================
// smin_pkg : shared mode encoding and compare helpers for the smin_reduce block
// Revision : 1.0
// ============================================================================
`default_nettype none

package smin_pkg;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Internal compare width; callers sign-extend their WIDTH-bit values into it.
  localparam int CMP_W = 64;

  // Neutral element: +max for min mode, -max-1 for max mode. Truncate to width.
  function automatic logic signed [CMP_W-1:0] neutral(input logic mode, input int width);
    logic signed [CMP_W-1:0] one_v;
    one_v = CMP_W'(1);
    if (mode == MODE_MAX) begin
      return -(one_v <<< (width - 1));
    end
    return (one_v <<< (width - 1)) - one_v;
  endfunction

  // Strict improvement test: ties keep the incumbent.
  function automatic logic better(input logic                    mode,
                                  input logic signed [CMP_W-1:0] cand,
                                  input logic signed [CMP_W-1:0] cur);
    return (mode == MODE_MAX) ? (cand > cur) : (cand < cur);
  endfunction

endpackage

`default_nettype wire

// File: rtl/smin_reduce_if.sv
// ============================================================================
// smin_reduce_if : clock, reset and beat/result signals of smin_reduce
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface smin_reduce_if #(
  parameter int WIDTH  = 16,
  parameter int N      = 8,
  parameter int BEAT_W = 8
);
  localparam int IDX_W = $clog2(N);

  logic                        clk;
  logic                        reset;
  logic                        in_valid;
  logic [N-1:0][WIDTH-1:0]     in_data;
  logic                        in_mode;
  logic                        in_last;
  logic                        out_valid;
  logic signed [WIDTH-1:0]     out_data;
  logic [IDX_W-1:0]            out_index;
  logic [BEAT_W-1:0]           out_beat;

  modport master (
    output clk, reset, in_valid, in_data, in_mode, in_last,
    input  out_valid, out_data, out_index, out_beat
  );

  modport slave (
    input  clk, reset, in_valid, in_data, in_mode, in_last,
    output out_valid, out_data, out_index, out_beat
  );

endinterface

`default_nettype wire

// File: rtl/smin_cmp2.sv
// ============================================================================
// smin_cmp2 : registered two-input signed compare/select with index and control
// Revision  : 1.0
// ============================================================================
`default_nettype none

module smin_cmp2
  import smin_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] i_a_val,
  input  logic [IDX_W-1:0]        i_a_idx,
  input  logic                    i_a_mode,
  input  logic                    i_a_last,
  input  logic                    i_a_valid,
  input  logic signed [WIDTH-1:0] i_b_val,
  input  logic [IDX_W-1:0]        i_b_idx,
  input  logic                    i_b_mode,
  input  logic                    i_b_last,
  input  logic                    i_b_valid,
  output logic signed [WIDTH-1:0] o_val,
  output logic [IDX_W-1:0]        o_idx,
  output logic                    o_mode,
  output logic                    o_last,
  output logic                    o_valid
);

  logic signed [WIDTH-1:0] val_d, val_q;
  logic [IDX_W-1:0]        idx_d, idx_q;
  logic                    mode_d, mode_q;
  logic                    last_d, last_q;
  logic                    valid_d, valid_q;
  logic                    w_take_b;

  // Both children belong to the same beat, so their control bits agree;
  // folding them keeps each child output live.
  always_comb begin
    mode_d   = i_a_mode | i_b_mode;
    last_d   = i_a_last & i_b_last;
    valid_d  = i_a_valid & i_b_valid;
    w_take_b = better(mode_d, CMP_W'(i_b_val), CMP_W'(i_a_val));
    val_d    = w_take_b ? i_b_val : i_a_val;
    idx_d    = w_take_b ? i_b_idx : i_a_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign o_val   = val_q;
  assign o_idx   = idx_q;
  assign o_mode  = mode_q;
  assign o_last  = last_q;
  assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/smin_reduce.sv
// ============================================================================
// smin_reduce : pipelined signed min/max reduction over N channels and
//               multi-beat frames, reporting winner value, channel and beat
// Revision    : 1.0
// ============================================================================
`default_nettype none

module smin_reduce
  import smin_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N      = 8,
  parameter int BEAT_W = 8
) (
  smin_reduce_if.slave g
);

  localparam int IDX_W = $clog2(N);
  localparam int D     = IDX_W;
  localparam int P     = 1 << D;
  localparam int NODES = 2 * P - 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  // Heap-ordered tree: node k has children 2k+1/2k+2, leaves at P-1..2P-2.
  logic signed [WIDTH-1:0] node_val   [NODES];
  logic [IDX_W-1:0]        node_idx   [NODES];
  logic                    node_mode  [NODES];
  logic                    node_last  [NODES];
  logic                    node_valid [NODES];

  logic in_frame_d, in_frame_q;
  logic frame_mode_d, frame_mode_q;
  logic beat_mode;

  // Later beats of a frame reuse the mode captured on the first beat.
  always_comb begin
    in_frame_d   = in_frame_q;
    frame_mode_d = frame_mode_q;
    if (g.in_valid) begin
      if (!in_frame_q) begin
        frame_mode_d = g.in_mode;
      end
      in_frame_d = !g.in_last;
    end
    beat_mode = in_frame_q ? frame_mode_q : g.in_mode;
  end

  always_ff @(posedge g.clk or posedge g.reset) begin
    if (g.reset) begin
      in_frame_q   <= 1'b0;
      frame_mode_q <= MODE_MIN;
    end else begin
      in_frame_q   <= in_frame_d;
      frame_mode_q <= frame_mode_d;
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N) begin : g_real
      assign node_val[P-1+i] = $signed(g.in_data[i]);
    end else begin : g_pad
      assign node_val[P-1+i] = WIDTH'(neutral(beat_mode, WIDTH));
    end
    assign node_idx[P-1+i]   = IDX_W'(i);
    assign node_mode[P-1+i]  = beat_mode;
    assign node_last[P-1+i]  = g.in_last;
    assign node_valid[P-1+i] = g.in_valid;
  end

  for (genvar k = 0; k < P - 1; k++) begin : g_node
    smin_cmp2 #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
    ) u_cmp (
      .clk       (g.clk),
      .rst       (g.reset),
      .i_a_val   (node_val[2*k+1]),
      .i_a_idx   (node_idx[2*k+1]),
      .i_a_mode  (node_mode[2*k+1]),
      .i_a_last  (node_last[2*k+1]),
      .i_a_valid (node_valid[2*k+1]),
      .i_b_val   (node_val[2*k+2]),
      .i_b_idx   (node_idx[2*k+2]),
      .i_b_mode  (node_mode[2*k+2]),
      .i_b_last  (node_last[2*k+2]),
      .i_b_valid (node_valid[2*k+2]),
      .o_val     (node_val[k]),
      .o_idx     (node_idx[k]),
      .o_mode    (node_mode[k]),
      .o_last    (node_last[k]),
      .o_valid   (node_valid[k])
    );
  end

  logic [0:0]              state_d, state_q;
  logic signed [WIDTH-1:0] acc_val_d, acc_val_q;
  logic [IDX_W-1:0]        acc_idx_d, acc_idx_q;
  logic [BEAT_W-1:0]       acc_beat_d, acc_beat_q;
  logic [BEAT_W-1:0]       cnt_d, cnt_q;
  logic                    acc_mode_d, acc_mode_q;
  logic                    out_valid_d, out_valid_q;
  logic signed [WIDTH-1:0] out_data_d, out_data_q;
  logic [IDX_W-1:0]        out_index_d, out_index_q;
  logic [BEAT_W-1:0]       out_beat_d, out_beat_q;
  logic                    take;

  always_comb begin
    state_d     = state_q;
    acc_val_d   = acc_val_q;
    acc_idx_d   = acc_idx_q;
    acc_beat_d  = acc_beat_q;
    cnt_d       = cnt_q;
    acc_mode_d  = acc_mode_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_beat_d  = out_beat_q;
    take        = 1'b0;
    if (node_valid[0]) begin
      if (state_q == ST_IDLE) begin
        acc_val_d  = node_val[0];
        acc_idx_d  = node_idx[0];
        acc_beat_d = '0;
        cnt_d      = BEAT_W'(1);
        acc_mode_d = node_mode[0];
      end else begin
        take = better(acc_mode_q, CMP_W'(node_val[0]), CMP_W'(acc_val_q));
        if (take) begin
          acc_val_d  = node_val[0];
          acc_idx_d  = node_idx[0];
          acc_beat_d = cnt_q;
        end
        if (cnt_q != BEAT_MAX) begin
          cnt_d = cnt_q + BEAT_W'(1);
        end
      end
      if (node_last[0]) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
        out_data_d  = acc_val_d;
        out_index_d = acc_idx_d;
        out_beat_d  = acc_beat_d;
      end else begin
        state_d = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge g.clk or posedge g.reset) begin
    if (g.reset) begin
      state_q     <= ST_IDLE;
      acc_val_q   <= '0;
      acc_idx_q   <= '0;
      acc_beat_q  <= '0;
      cnt_q       <= '0;
      acc_mode_q  <= MODE_MIN;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_beat_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_val_q   <= acc_val_d;
      acc_idx_q   <= acc_idx_d;
      acc_beat_q  <= acc_beat_d;
      cnt_q       <= cnt_d;
      acc_mode_q  <= acc_mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_beat_q  <= out_beat_d;
    end
  end

  assign g.out_valid = out_valid_q;
  assign g.out_data  = out_data_q;
  assign g.out_index = out_index_q;
  assign g.out_beat  = out_beat_q;

endmodule

`default_nettype wire

// File: tb/tb_smin_reduce.sv
// ============================================================================
// tb_smin_reduce : scoreboard bench for smin_reduce (N=8 and padded N=5)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_smin_reduce;
  import smin_pkg::*;

  localparam int W        = 16;
  localparam int BW       = 8;
  localparam int N8       = 8;
  localparam int N5       = 5;
  localparam int LAT8     = $clog2(N8) + 1;
  localparam int LAT5     = $clog2(N5) + 1;
  localparam int BEAT_CAP = (1 << BW) - 1;

  typedef struct {
    int data;
    int index;
    int beat;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t q8[$];
  exp_t q5[$];
  int   vals8[$];
  int   vals5[$];
  bit   act8 = 1'b0;
  bit   act5 = 1'b0;
  logic mode8 = 1'b0;
  logic mode5 = 1'b0;
  int   d8[N8];
  int   d5[N5];

  smin_reduce_if #(.WIDTH(W), .N(N8), .BEAT_W(BW)) g8 ();
  smin_reduce_if #(.WIDTH(W), .N(N5), .BEAT_W(BW)) g5 ();

  assign g8.clk   = clk;
  assign g8.reset = rst;
  assign g5.clk   = clk;
  assign g5.reset = rst;

  smin_reduce #(.WIDTH(W), .N(N8), .BEAT_W(BW)) dut8 (.g(g8.slave));
  smin_reduce #(.WIDTH(W), .N(N5), .BEAT_W(BW)) dut5 (.g(g5.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: scan the whole frame beat-major, channel-minor; strict
  // improvement keeps the earliest beat and lowest channel on ties.
  function automatic exp_t model(input int v[$], input int n, input logic m, input int c);
    exp_t e;
    int   best;
    int   bk;
    best = v[0];
    bk   = 0;
    for (int k = 1; k < v.size(); k++) begin
      if ((m == MODE_MAX) ? (v[k] > best) : (v[k] < best)) begin
        best = v[k];
        bk   = k;
      end
    end
    e.data  = best;
    e.index = bk % n;
    e.beat  = (bk / n > BEAT_CAP) ? BEAT_CAP : bk / n;
    e.cyc   = c;
    return e;
  endfunction

  function automatic int rv();
    logic signed [15:0] t;
    t = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 4)) - 2;
      1:       return t[0] ? 32767 : -32768;
      default: return int'(t);
    endcase
  endfunction

  task automatic beat8(input bit v, input int d[N8], input logic m, input bit l);
    @(negedge clk);
    g8.in_valid = v;
    g8.in_mode  = m;
    g8.in_last  = l;
    for (int i = 0; i < N8; i++) g8.in_data[i] = 16'(d[i]);
    if (v) begin
      if (!act8) begin
        act8  = 1'b1;
        mode8 = m;
        vals8.delete();
      end
      for (int i = 0; i < N8; i++) vals8.push_back(d[i]);
      if (l) begin
        q8.push_back(model(vals8, N8, mode8, cyc + LAT8));
        act8 = 1'b0;
      end
    end
  endtask

  task automatic beat5(input bit v, input int d[N5], input logic m, input bit l);
    @(negedge clk);
    g5.in_valid = v;
    g5.in_mode  = m;
    g5.in_last  = l;
    for (int i = 0; i < N5; i++) g5.in_data[i] = 16'(d[i]);
    if (v) begin
      if (!act5) begin
        act5  = 1'b1;
        mode5 = m;
        vals5.delete();
      end
      for (int i = 0; i < N5; i++) vals5.push_back(d[i]);
      if (l) begin
        q5.push_back(model(vals5, N5, mode5, cyc + LAT5));
        act5 = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      g8.in_valid = 1'b0;
      g8.in_last  = 1'b0;
      g5.in_valid = 1'b0;
      g5.in_last  = 1'b0;
    end
  endtask

  task automatic rand_frames8(input int nf, input bit gaps, input int max_beats);
    for (int f = 0; f < nf; f++) begin
      int   nb;
      logic m;
      nb = $urandom_range(1, max_beats);
      m  = 1'($urandom);
      for (int b = 0; b < nb; b++) begin
        foreach (d8[i]) d8[i] = rv();
        beat8(1'b1, d8, (b == 0) ? m : 1'($urandom), b == nb - 1);
        if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
  endtask

  task automatic rand_frames5(input int nf);
    for (int f = 0; f < nf; f++) begin
      int   nb;
      logic m;
      nb = $urandom_range(1, 3);
      m  = 1'($urandom);
      for (int b = 0; b < nb; b++) begin
        foreach (d5[i]) d5[i] = rv();
        beat5(1'b1, d5, (b == 0) ? m : 1'($urandom), b == nb - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_v8"},   int'(g8.out_valid), 0);
    check({tag, "_d8"},   int'(g8.out_data),  0);
    check({tag, "_i8"},   int'(g8.out_index), 0);
    check({tag, "_b8"},   int'(g8.out_beat),  0);
    check({tag, "_v5"},   int'(g5.out_valid), 0);
    check({tag, "_d5"},   int'(g5.out_data),  0);
  endtask

  always @(negedge clk) begin
    if (g8.out_valid) begin
      exp_t e;
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut8_pulse: got out_valid=1, expected no pulse (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("dut8_data",  int'($signed(g8.out_data)), e.data);
        check("dut8_index", int'(g8.out_index),         e.index);
        check("dut8_beat",  int'(g8.out_beat),          e.beat);
        check("dut8_cycle", cyc,                        e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (g5.out_valid) begin
      exp_t e;
      if (q5.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut5_pulse: got out_valid=1, expected no pulse (cycle %0d)", cyc);
      end else begin
        e = q5.pop_front();
        check("dut5_data",  int'($signed(g5.out_data)), e.data);
        check("dut5_index", int'(g5.out_index),         e.index);
        check("dut5_beat",  int'(g5.out_beat),          e.beat);
        check("dut5_cycle", cyc,                        e.cyc);
      end
    end
  end

  initial begin
    g8.in_valid = 1'b0; g8.in_last = 1'b0; g8.in_mode = 1'b0; g8.in_data = '0;
    g5.in_valid = 1'b0; g5.in_last = 1'b0; g5.in_mode = 1'b0; g5.in_data = '0;
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst = 1'b0;
    idle(2);

    // N=8 directed single-beat frames
    d8 = '{5, -3, 7, -3, 0, 9, -32768, 1};
    beat8(1'b1, d8, MODE_MIN, 1'b1);
    beat8(1'b1, d8, MODE_MAX, 1'b1);
    d8 = '{4, 4, 4, 4, 4, 4, 4, 4};
    beat8(1'b1, d8, MODE_MAX, 1'b1);
    beat8(1'b1, d8, MODE_MIN, 1'b1);
    idle(LAT8 + 2);

    // Three beats with gaps, in_mode flipped on the last beat
    d8 = '{10, 20, 30, 40, 50, 60, 70, 80};
    beat8(1'b1, d8, MODE_MIN, 1'b0);
    idle(2);
    d8 = '{100, -7, 5, 3, -7, 90, 11, 12};
    beat8(1'b1, d8, MODE_MIN, 1'b0);
    idle(1);
    d8 = '{-7, 30, 90, 0, -7, 1, 2, 3};
    beat8(1'b1, d8, MODE_MAX, 1'b1);
    idle(LAT8 + 2);

    // Reset while an unfinished frame is in the pipeline
    d8 = '{3, 3, 3, 3, 3, 3, 3, 3};
    beat8(1'b1, d8, MODE_MIN, 1'b0);
    beat8(1'b1, d8, MODE_MIN, 1'b0);
    idle(2);
    @(negedge clk);
    rst  = 1'b1;
    act8 = 1'b0;
    #1;
    reset_checks("async_rst");
    repeat (3) @(negedge clk);
    reset_checks("held_rst");
    rst = 1'b0;
    idle(1);
    d8 = '{40, -1, 7, 200, -1, 6, 8, 9};
    beat8(1'b1, d8, MODE_MIN, 1'b1);
    idle(LAT8 + 2);

    // Back-to-back single-beat frames, then random multi-beat frames
    rand_frames8(20, 1'b0, 1);
    rand_frames8(40, 1'b1, 4);
    idle(LAT8 + 2);

    // Long frame: winner beyond the saturating beat counter
    for (int b = 0; b < 260; b++) begin
      foreach (d8[i]) d8[i] = $urandom_range(0, 1000);
      if (b == 258) d8[2] = -5000;
      beat8(1'b1, d8, MODE_MIN, b == 259);
    end
    idle(LAT8 + 2);

    // N=5 padded tree
    d5 = '{2, 2, 2, 2, 2};
    beat5(1'b1, d5, MODE_MIN, 1'b1);
    d5 = '{-32768, -32768, -32768, -32768, -32768};
    beat5(1'b1, d5, MODE_MAX, 1'b1);
    d5 = '{32767, 32767, 32767, 32767, 32767};
    beat5(1'b1, d5, MODE_MIN, 1'b1);
    d5 = '{-5, 0, 3, -9, 17};
    beat5(1'b1, d5, MODE_MAX, 1'b1);
    rand_frames5(25);
    idle(LAT5 + 4);

    check("q8_drained", q8.size(), 0);
    check("q5_drained", q5.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
